// File: rtl/parity_serializer_if.sv
// ---------------------------------------------------------------------------
// parity_serializer_if
// Bundles the word handshake and the serial output of parity_serializer.
//
// Handshake: a word moves when in_valid and in_ready are both high on a
// rising clk edge. in_valid may be asserted at any time and must then hold
// in_data/mode (and err_inject, when present) stable until that edge.
// valid_out qualifies data_out. The serial side has no backpressure.
//
// Signals:
//   in_data    [WIDTH-1:0]  parallel payload          (master -> slave)
//   in_valid                upstream word valid       (master -> slave)
//   in_ready                block can accept a word   (slave  -> master)
//   mode                    0 even, 1 odd parity      (master -> slave)
//   err_inject              invert parity bit         (master -> slave,
//                           only with PARITY_ERR_INJECT_EN defined)
//   data_out                serial bit                (slave  -> master)
//   valid_out               qualifies data_out        (slave  -> master)
//   frame_done              high on the parity bit    (slave  -> master)
//   busy                    not idle                  (slave  -> master)
//
// Optional macro: PARITY_ERR_INJECT_EN adds err_inject.
// ---------------------------------------------------------------------------
interface parity_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             mode;
`ifdef PARITY_ERR_INJECT_EN
    logic             err_inject;
`endif
    logic             data_out;
    logic             valid_out;
    logic             frame_done;
    logic             busy;

    modport master (
        output in_data, in_valid, mode,
`ifdef PARITY_ERR_INJECT_EN
        output err_inject,
`endif
        input  in_ready, data_out, valid_out, frame_done, busy
    );

    modport slave (
        input  in_data, in_valid, mode,
`ifdef PARITY_ERR_INJECT_EN
        input  err_inject,
`endif
        output in_ready, data_out, valid_out, frame_done, busy
    );
endinterface

// File: rtl/parity_serializer.sv
// ---------------------------------------------------------------------------
// parity_serializer
// Accepts a WIDTH-bit word, sends it LSB-first on data_out with valid_out,
// appends one parity bit (XOR of all emitted bits == latched mode), then
// holds valid_out low for GAP cycles so the downstream checker sees the
// frame boundary.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   bus        parity_serializer_if.slave (handshake + serial output)
//   state_dbg  current FSM state (0 IDLE, 1 SHIFT, 2 PARITY, 3 GAP)
//
// Parameters:
//   WIDTH  payload bits per frame (>= 2)
//   GAP    idle cycles after each parity bit (>= 1)
//
// Optional macro: PARITY_ERR_INJECT_EN -- err_inject sampled at accept
// inverts the parity bit of that frame.
// ---------------------------------------------------------------------------
module parity_serializer #(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    parity_serializer_if.slave     bus,
    output logic [1:0]             state_dbg
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

    generate
        if (GAP < 1) begin : g_bad_gap
            $error("parity_serializer: GAP must be >= 1");
        end
        if (WIDTH < 2) begin : g_bad_width
            $error("parity_serializer: WIDTH must be >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2,
        S_GAP    = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             mode_q;
    logic             dxor_q;     // XOR of the payload (and err_inject)
    logic             data_q;
    logic             valid_q;
    logic             done_q;
    logic             in_ready;
    logic             accept;
    logic             inj;

`ifdef PARITY_ERR_INJECT_EN
    assign inj = bus.err_inject;
`else
    assign inj = 1'b0;
`endif

    assign in_ready = (state == S_IDLE);
    assign accept   = bus.in_valid && in_ready;

    // Bit 0 of the word goes straight into the output register at accept,
    // so the shift register is loaded already advanced by one position and
    // its bit 0 always holds the next bit to emit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            mode_q  <= 1'b0;
            dxor_q  <= 1'b0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        shreg   <= {1'b0, bus.in_data[WIDTH-1:1]};
                        bit_cnt <= '0;
                        mode_q  <= bus.mode;
                        dxor_q  <= (^bus.in_data) ^ inj;
                        data_q  <= bus.in_data[0];
                        valid_q <= 1'b1;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bit_cnt == BIT_LAST) begin
                        data_q <= mode_q ^ dxor_q;
                        done_q <= 1'b1;
                        state  <= S_PARITY;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        data_q  <= shreg[0];
                        shreg   <= shreg >> 1;
                    end
                end
                S_PARITY: begin
                    data_q  <= 1'b0;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    gap_cnt <= '0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.data_out   = data_q;
    assign bus.valid_out  = valid_q;
    assign bus.frame_done = done_q;
    assign bus.busy       = (state != S_IDLE);
    assign state_dbg      = state;
endmodule

// File: tb/tb_parity_serializer.sv
module tb_parity_serializer;
    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   cyc;

    parity_serializer_if #(.WIDTH(8)) a_if ();
    parity_serializer_if #(.WIDTH(8)) b_if ();
    logic [1:0] a_state;
    logic [1:0] b_state;

    parity_serializer #(.WIDTH(8), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .bus(a_if.slave), .state_dbg(a_state)
    );
    parity_serializer #(.WIDTH(8), .GAP(3)) dut_b (
        .clk(clk), .reset(reset), .bus(b_if.slave), .state_dbg(b_state)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Collect the 9 serial cycles of a frame on dut_a, starting at the
    // negedge of the first bit cycle; ends on the negedge of the gap cycle.
    task automatic collect_a(input logic [7:0] exp_bits, input logic exp_par, input logic m);
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("a_bit%0d", i), a_if.data_out, exp_bits[i]);
            check("a_valid_data", a_if.valid_out, 1);
            check("a_done_low", a_if.frame_done, 0);
            acc ^= a_if.data_out;
            @(negedge clk);
        end
        check("a_parity", a_if.data_out, exp_par);
        check("a_valid_par", a_if.valid_out, 1);
        check("a_done_par", a_if.frame_done, 1);
        acc ^= a_if.data_out;
        check("a_frame_xor", acc, m);
        @(negedge clk);
    endtask

    // Send one word on dut_a and check the full frame plus trailing gap.
    task automatic run_frame(input logic [7:0] d, input logic m, input logic ei,
                             input logic [7:0] exp_bits, input logic exp_par);
        int t;
        @(negedge clk);
        a_if.in_data  = d;
        a_if.mode     = m;
        a_if.in_valid = 1'b1;
`ifdef PARITY_ERR_INJECT_EN
        a_if.err_inject = ei;
`else
        if (ei) $display("note: err_inject ignored in this build");
`endif
        t = 0;
        while (!a_if.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("a_accept_wait", (t < 50), 1);
        @(negedge clk);
        // Scramble inputs after accept: the frame must be unaffected.
        a_if.in_valid = 1'b0;
        a_if.in_data  = ~d;
        a_if.mode     = ~m;
`ifdef PARITY_ERR_INJECT_EN
        a_if.err_inject = ~ei;
`endif
        collect_a(exp_bits, exp_par, m);
        check("a_gap_valid", a_if.valid_out, 0);
        check("a_gap_data", a_if.data_out, 0);
        check("a_gap_ready", a_if.in_ready, 0);
        check("a_gap_busy", a_if.busy, 1);
        @(negedge clk);
        check("a_ready_back", a_if.in_ready, 1);
        check("a_busy_back", a_if.busy, 0);
`ifdef PARITY_ERR_INJECT_EN
        a_if.err_inject = 1'b0;
`endif
    endtask

    initial begin
        int acc1;
        int acc2;
        int low;
        int t;
        checks   = 0;
        failures = 0;
        cyc      = 0;
        reset    = 1'b1;
        a_if.in_data = '0; a_if.in_valid = 1'b0; a_if.mode = 1'b0;
        b_if.in_data = '0; b_if.in_valid = 1'b0; b_if.mode = 1'b0;
`ifdef PARITY_ERR_INJECT_EN
        a_if.err_inject = 1'b0;
        b_if.err_inject = 1'b0;
`endif
        #1;
        check("rst_ready", a_if.in_ready, 1);
        check("rst_valid", a_if.valid_out, 0);
        check("rst_data", a_if.data_out, 0);
        check("rst_done", a_if.frame_done, 0);
        check("rst_busy", a_if.busy, 0);
        check("rst_state", a_state, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: A5 even -> bits 1,0,1,0,0,1,0,1 parity 0
        run_frame(8'hA5, 1'b0, 1'b0, 8'hA5, 1'b0);
        // A5 odd -> parity 1
        run_frame(8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1);
        // 2: 01 odd -> parity 0
        run_frame(8'h01, 1'b1, 1'b0, 8'h01, 1'b0);

        // 3: back-to-back on GAP=1, 3C then FF held on in_valid
        @(negedge clk);
        a_if.in_data = 8'h3C; a_if.mode = 1'b0; a_if.in_valid = 1'b1;
        check("b2b_ready1", a_if.in_ready, 1);
        acc1 = cyc;
        @(negedge clk);
        a_if.in_data = 8'hFF;
        low = 0;
        t = 0;
        while (!a_if.in_ready && t < 40) begin
            if (!a_if.valid_out) low++;
            @(negedge clk);
            t++;
        end
        acc2 = cyc;
        check("b2b_period", acc2 - acc1, 11);
        check("b2b_low_cycles", low, 1);
        @(negedge clk);
        a_if.in_valid = 1'b0;
        collect_a(8'hFF, 1'b0, 1'b0);
        check("b2b_gap_valid", a_if.valid_out, 0);
        @(negedge clk);

        // 4: GAP=3 back-to-back on dut_b, 55 then AA (odd)
        b_if.in_data = 8'h55; b_if.mode = 1'b1; b_if.in_valid = 1'b1;
        check("g3_ready1", b_if.in_ready, 1);
        acc1 = cyc;
        @(negedge clk);
        b_if.in_data = 8'hAA;
        low = 0;
        t = 0;
        while (!b_if.in_ready && t < 40) begin
            if (!b_if.valid_out) begin
                low++;
                check("g3_busy_in_gap", b_if.busy, 1);
            end
            @(negedge clk);
            t++;
        end
        acc2 = cyc;
        check("g3_period", acc2 - acc1, 13);
        check("g3_low_cycles", low, 3);
        @(negedge clk);
        b_if.in_valid = 1'b0;
        t = 0;
        while (b_if.busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("g3_drain", (t < 40), 1);

        // 5: reset at the 5th bit of F0 (bit4 = 1, so data_out is high)
        @(negedge clk);
        a_if.in_data = 8'hF0; a_if.mode = 1'b0; a_if.in_valid = 1'b1;
        @(negedge clk);
        a_if.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_bit4", a_if.data_out, 1);
        check("mid_valid", a_if.valid_out, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", a_if.valid_out, 0);
        check("mid_rst_data", a_if.data_out, 0);
        check("mid_rst_ready", a_if.in_ready, 1);
        check("mid_rst_busy", a_if.busy, 0);
        @(negedge clk);
        reset = 1'b0;
        check("post_rst_ready", a_if.in_ready, 1);
        run_frame(8'h80, 1'b0, 1'b0, 8'h80, 1'b1);

`ifdef PARITY_ERR_INJECT_EN
        // 6: error injection
        run_frame(8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1);
        run_frame(8'hFF, 1'b0, 1'b0, 8'hFF, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall time bound.
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout: got=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
